// File: rtl/req_grant_pkg.sv
// rtl/req_grant_pkg.sv - shared defaults, lane vector type and popcount helper
package req_grant_pkg;

    localparam int DEF_WIDTH        = 11;
    localparam int DEF_ACTIVE_LANES = 2;
    localparam int DEF_CNT_W        = 8;

    // popcount works on a fixed-width container so any lane count up to 64 fits
    localparam int POP_MAX_W = 64;
    localparam int POP_W     = 7;

    typedef logic [DEF_WIDTH-1:0] lane_vec_t;

    function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/req_grant_lane.sv
// rtl/req_grant_lane.sv - two-stage per-lane shift: accepted -> grant -> done stage
module req_grant_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic i_acc,
    output logic o_grant,
    output logic o_stg2
);

    logic r_grant;
    logic r_stg2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= 1'b0;
            r_stg2  <= 1'b0;
        end else begin
            r_grant <= i_acc;
            r_stg2  <= r_grant;
        end
    end

    assign o_grant = r_grant;
    assign o_stg2  = r_stg2;

endmodule

// File: rtl/req_grant_responder.sv
// rtl/req_grant_responder.sv - per-lane req/grant/done responder with completion counter
module req_grant_responder
    import req_grant_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int ACTIVE_LANES = DEF_ACTIVE_LANES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             act_en,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] resp_cnt,
    input  logic             cnt_clr
);

    localparam int SUM_W = CNT_W + POP_W;

    logic [WIDTH-1:0]     w_acc;
    logic [WIDTH-1:0]     w_grant;
    logic [WIDTH-1:0]     w_stg2;
    logic [POP_MAX_W-1:0] w_stg2_ext;
    logic [POP_W-1:0]     w_pop;
    logic [SUM_W-1:0]     w_sum;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 r_done;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_unused_req;

    // Lanes above ACTIVE_LANES keep their shift registers but never see an accept
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        if (i < ACTIVE_LANES) begin : g_active
            assign w_acc[i] = act_en & req[i];
        end else begin : g_gated
            assign w_acc[i] = 1'b0;
        end

        req_grant_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_acc   (w_acc[i]),
            .o_grant (w_grant[i]),
            .o_stg2  (w_stg2[i])
        );
    end

    assign w_unused_req = &{1'b0, req};

    assign w_stg2_ext = POP_MAX_W'(w_stg2);
    assign w_pop      = popcount(w_stg2_ext);
    assign w_sum      = SUM_W'(r_cnt) + SUM_W'(w_pop);

    always_comb begin
        w_cnt_next = r_cnt;
        if (cnt_clr) begin
            w_cnt_next = '0;
        end else if (w_sum > SUM_W'({CNT_W{1'b1}})) begin
            w_cnt_next = {CNT_W{1'b1}};
        end else begin
            w_cnt_next = w_sum[CNT_W-1:0];
        end
    end

    // done mirrors |stg2: one shared strobe however many lanes complete together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= |w_grant;
            r_cnt  <= w_cnt_next;
        end
    end

    assign grant    = w_grant;
    assign done     = r_done;
    assign busy     = (|w_grant) | (|w_stg2);
    assign resp_cnt = r_cnt;

endmodule

// File: tb/tb_req_grant_responder.sv
// tb/tb_req_grant_responder.sv - scoreboard bench with directed and random stimulus
module tb_req_grant_responder;

    localparam int W = 11;

    logic         clk;
    logic         rst_n;
    logic         act_en;
    logic [W-1:0] req;
    logic         cnt_clr;

    logic [W-1:0] grant_a, grant_b;
    logic         done_a, done_b, busy_a, busy_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    req_grant_responder u_dut (
        .clk(clk), .rst_n(rst_n), .act_en(act_en), .req(req),
        .grant(grant_a), .done(done_a), .busy(busy_a), .resp_cnt(cnt_a), .cnt_clr(cnt_clr)
    );

    req_grant_responder #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .act_en(act_en), .req(req),
        .grant(grant_b), .done(done_b), .busy(busy_b), .resp_cnt(cnt_b), .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic [W-1:0] g;
        logic         d;
        logic         b;
        int           c8;
        int           c2;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: outputs in a cycle are the accepted set of one cycle ago (grant)
    // and two cycles ago (done); the counter totals completions, clamped.
    logic [W-1:0] acc_1ago = '0;
    logic [W-1:0] acc_2ago = '0;
    int           tot8 = 0;
    int           tot2 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic drive(input logic rst, input logic a, input logic [W-1:0] r, input logic c);
        exp_t e;
        int   completed;
        @(posedge clk);
        #1;
        rst_n   = rst;
        act_en  = a;
        req     = r;
        cnt_clr = c;
        if (!rst) begin
            acc_1ago = '0;
            acc_2ago = '0;
            tot8     = 0;
            tot2     = 0;
        end
        e.g  = acc_1ago;
        e.d  = (acc_2ago != '0);
        e.b  = (acc_1ago != '0) || (acc_2ago != '0);
        e.c8 = tot8;
        e.c2 = tot2;
        exp_q.push_back(e);
        if (rst) begin
            completed = $countones(acc_2ago);
            tot8      = c ? 0 : min_int(tot8 + completed, 255);
            tot2      = c ? 0 : min_int(tot2 + completed, 3);
            acc_2ago  = acc_1ago;
            acc_1ago  = a ? (r & 11'b000_0000_0011) : '0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant",      int'(grant_a), int'(e.g));
            check("done",       int'(done_a),  int'(e.d));
            check("busy",       int'(busy_a),  int'(e.b));
            check("resp_cnt",   int'(cnt_a),   e.c8);
            check("grant_c2",   int'(grant_b), int'(e.g));
            check("done_c2",    int'(done_b),  int'(e.d));
            check("resp_cnt_c2", int'(cnt_b),  e.c2);
        end
    end

    initial begin
        rst_n   = 1'b0;
        act_en  = 1'b0;
        req     = '0;
        cnt_clr = 1'b0;

        drive(0, 0, '0, 0);
        drive(0, 0, '0, 0);

        // single request on lane 0
        drive(1, 1, 11'b1, 0);
        repeat (4) drive(1, 0, '0, 0);

        // all lanes requested: only the serviced lanes answer
        drive(1, 1, 11'h7FF, 0);
        repeat (4) drive(1, 0, '0, 0);

        // requests without activation are ignored
        drive(1, 0, 11'b11, 0);
        repeat (3) drive(1, 0, '0, 0);

        // back-to-back on lane 1 with act_en dropping in the third cycle
        drive(1, 1, 11'b10, 0);
        drive(1, 1, 11'b10, 0);
        drive(1, 0, 11'b10, 0);
        repeat (4) drive(1, 0, '0, 0);

        // five singles drive the 2-bit counter into saturation
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 11'b1, 0);
            drive(1, 0, '0, 0);
        end
        repeat (3) drive(1, 0, '0, 0);

        // clear coinciding with a completion wins
        drive(1, 1, 11'b1, 0);
        drive(1, 0, '0, 0);
        drive(1, 0, '0, 1);
        repeat (3) drive(1, 0, '0, 0);

        // reset while a request is in flight
        drive(1, 1, 11'b1, 0);
        drive(0, 0, '0, 0);
        repeat (4) drive(1, 0, '0, 0);

        for (int k = 0; k < 10000; k++) begin
            drive(($urandom_range(0, 499) != 0),
                  ($urandom_range(0, 3) != 0),
                  W'($urandom),
                  ($urandom_range(0, 63) == 0));
        end

        repeat (4) drive(1, 0, '0, 0);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/req_grant_responder.md
Name: req_grant_responder

Overview:
- Responder side of the per-lane request/grant/done handshake.
- When the activation condition is high, every request bit sampled on lane i is answered with grant[i] one cycle later and a shared done pulse one cycle after that.
- Sits between the request-issuing datapath and the downstream consumer. It is the driving end for the handshake the environment is constrained to follow (req[i] |=> grant[i] ##1 done).
- Multiple lanes and back-to-back requests are fully pipelined.

Parameters:
- WIDTH, 11, number of request/grant lanes.
- ACTIVE_LANES, 2, lanes 0..ACTIVE_LANES-1 are serviced; higher lanes are ignored. Legal range is 1..WIDTH.
- CNT_W, 8, width of the saturating completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- act_en  input  1  activation condition; a request is accepted only when act_en=1 in the same cycle.
- req  input  WIDTH  per-lane request bits, sampled at posedge clk.
- grant  output  WIDTH  per-lane grant, registered.
- done  output  1  shared completion strobe, registered.
- busy  output  1  high while any accepted request has not yet produced done.
- resp_cnt  output  CNT_W  count of completed lane-transactions, saturating.
- cnt_clr  input  1  synchronous clear of resp_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous): grant=0, done=0, busy=0, resp_cnt=0, all pipeline stages cleared. A reset mid-transaction drops all in-flight requests; nothing is emitted after release until new requests arrive.
- Acceptance at cycle t: acc[i] = act_en & req[i] & (i < ACTIVE_LANES). Lanes >= ACTIVE_LANES never assert grant.
- Stage 1: grant[i] is asserted during cycle t+1 for exactly one cycle per accepted request. The stage register is acc itself.
- Stage 2: stg2[i] = grant[i] delayed one cycle. done = |stg2, asserted during cycle t+2.
- Latency is fixed: request to grant is 1 cycle; request to done is 2 cycles. There is no backpressure.
- Back-to-back: req[i] held high for N cycles with act_en=1 gives grant[i] high for N cycles starting at t+1 and done high for N cycles starting at t+2.
- Simultaneous lanes: requests on several lanes in the same cycle produce parallel grants and a single done pulse.
- act_en dropping after acceptance does not cancel in-flight grant or done; already-accepted transactions always complete.
- busy = |acc_reg | |stg2, i.e. high from cycle t+1 through cycle t+2 inclusive.
- resp_cnt adds popcount(stg2) each cycle and saturates at 2^CNT_W-1, with no wrap.
- cnt_clr has priority over the increment: with cnt_clr=1, resp_cnt is 0 in the next cycle regardless of completions in that cycle.
- No FSM deadlock is possible: the pipeline is a pure shift structure. The per-lane state is conceptually IDLE -> GRANT -> DONE -> IDLE, with overlapping instances allowed.

Decomposition:
- Shared package req_grant_pkg:
  - default WIDTH/ACTIVE_LANES/CNT_W localparams;
  - the lane_vec_t typedef (logic [WIDTH-1:0]);
  - a popcount function.
- One natural sub-module, req_grant_lane: the 2-stage per-lane shift (acc -> grant -> stg2). It is instantiated WIDTH times via generate, and lanes >= ACTIVE_LANES are tied off.
- The top level holds the done OR-reduction, busy, and the counter.

Test Plan:
- Single request: act_en=1, req=11'b1 at cycle 0 -> grant=11'b1 at cycle 1, done=1 at cycle 2, busy=1 at cycles 1-2, resp_cnt=1 at cycle 3.
- Gated lanes: act_en=1, req=11'h7FF for 1 cycle -> grant=11'b11 only, one done pulse, resp_cnt=2. Separately, act_en=0 with req=11'b11 -> grant, done and busy all stay 0.
- Back-to-back with act_en drop: req[1]=1 for cycles 0-2, act_en=1 for cycles 0-1 only -> grant[1]=1 at cycles 1-2 (not 3), done=1 at cycles 2-3, resp_cnt=2.
- Counter behaviour: with CNT_W=2, five single requests -> resp_cnt saturates at 3. cnt_clr asserted in the same cycle as a completion -> resp_cnt=0 next cycle.
- Reset mid-flight: req=11'b1 at cycle 0, rst_n low during cycle 1 -> grant, done and busy are 0 immediately and stay 0 after release; resp_cnt=0.
- Continuous random: random req/act_en with a concurrent property check of act_en & req[i] |=> grant[i] ##1 done for i < ACTIVE_LANES -> no failures over 10k cycles.
